// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spike-rate decoder.
// Reconstruction maps a spike count back into the ANN activation domain.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_OUTPUT
  } dec_state_t;

  localparam int DEF_T          = 4;
  localparam int DEF_THRESHOLD  = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 2;

  // Width that holds count*threshold exactly.
  function automatic int prod_width(input int cnt_width, input int threshold);
    return cnt_width + $clog2(threshold + 1);
  endfunction

  // floor((count*threshold) >> log2_t), product truncated to prod_w bits,
  // then saturated to data_width bits.
  function automatic logic [31:0] reconstruct(
    input logic [31:0] count,
    input logic [31:0] threshold,
    input logic [31:0] log2_t,
    input logic [31:0] prod_w,
    input logic [31:0] data_width
  );
    logic [63:0] prod;
    logic [63:0] mask;
    logic [63:0] max_val;
    mask    = (64'd1 << prod_w) - 64'd1;
    prod    = ((64'(count) * 64'(threshold)) & mask) >> log2_t;
    max_val = (64'd1 << data_width) - 64'd1;
    return (prod > max_val) ? max_val[31:0] : prod[31:0];
  endfunction

endpackage

// File: rtl/spike_train_fifo.sv
// Small synchronous FIFO for spike trains; dout shows the head whenever not empty.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module spike_train_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Replays buffered spike trains one timestep per cycle, counts spikes and
// presents the rescaled activation on a valid/ready output port.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int T          = DEF_T,
  parameter int THRESHOLD  = DEF_THRESHOLD,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = $clog2(T + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [T-1:0]          spike_in,
  input  logic                  spike_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  input  logic                  data_ready,
  output logic [CNT_WIDTH-1:0]  spike_count,
  output logic                  overflow,
  output logic                  busy
);

  localparam int LOG2_T     = $clog2(T);
  localparam int PROD_WIDTH = prod_width(CNT_WIDTH, THRESHOLD);

  dec_state_t            state;
  logic [T-1:0]          shreg;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_next;
  logic [LOG2_T-1:0]     t_cnt;
  logic [DATA_WIDTH-1:0] recon;

  logic [T-1:0] fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         drop;

  spike_train_fifo #(
    .WIDTH(T),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (spike_valid),
    .din  (spike_in),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
  assign drop       = spike_valid && fifo_full && !fifo_pop;
  assign busy       = !fifo_empty || (state != ST_IDLE);
  assign count_next = count + CNT_WIDTH'(shreg[0]);
  // Includes the final timestep so the result registers on the last DECODE edge.
  assign recon      = DATA_WIDTH'(reconstruct(32'(count_next), 32'(THRESHOLD), 32'(LOG2_T),
                                              32'(PROD_WIDTH), 32'(DATA_WIDTH)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      shreg          <= '0;
      count          <= '0;
      t_cnt          <= '0;
      data_out       <= '0;
      spike_count    <= '0;
      data_valid_out <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shreg <= fifo_dout;
            count <= '0;
            t_cnt <= '0;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          count <= count_next;
          shreg <= shreg >> 1;
          t_cnt <= t_cnt + 1'b1;
          if (t_cnt == LOG2_T'(T - 1)) begin
            data_out       <= recon;
            spike_count    <= count_next;
            data_valid_out <= 1'b1;
            state          <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (data_ready) begin
            data_valid_out <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a queue-based timing model is checked
// every cycle, plus literal expectations for each scenario.
module tb_spike_rate_decoder;

  localparam int T     = 4;
  localparam int TH    = 8;
  localparam int DEPTH = 2;
  localparam int LOG2T = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] spike_in;
  logic       spike_valid;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic [2:0] spike_count;
  logic       overflow;
  logic       busy;
  logic [7:0] sat_data_out;
  logic       sat_valid;
  logic [2:0] sat_count;
  logic       sat_overflow;
  logic       sat_busy;

  always #5 clk = ~clk;

  spike_rate_decoder dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .spike_valid(spike_valid),
    .data_out(data_out), .data_valid_out(data_valid_out), .data_ready(data_ready),
    .spike_count(spike_count), .overflow(overflow), .busy(busy)
  );

  spike_rate_decoder #(.THRESHOLD(255)) dut_sat (
    .clk(clk), .rst(rst), .spike_in(spike_in), .spike_valid(spike_valid),
    .data_out(sat_data_out), .data_valid_out(sat_valid), .data_ready(data_ready),
    .spike_count(sat_count), .overflow(sat_overflow), .busy(sat_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int recon(input int c);
    int v;
    v = (c * TH) >> LOG2T;
    return (v > 255) ? 255 : v;
  endfunction

  // Model: a queue of buffered trains and a decoder that is idle, replaying
  // (m_rem timesteps left) or presenting a result.
  int m_q[$];
  int m_phase;
  int m_rem;
  int m_cur;
  int m_valid;
  int m_data;
  int m_cnt;
  int m_ovf;
  int cyc = 0;

  always @(posedge clk) begin
    int head;
    bit popped;
    cyc++;
    if (rst) begin
      m_q.delete();
      m_phase = 0; m_rem = 0; m_cur = 0;
      m_valid = 0; m_data = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      head   = 0;
      popped = (m_phase == 0) && (m_q.size() > 0);
      if (popped) head = m_q.pop_front();
      case (m_phase)
        2: if (data_ready) begin m_phase = 0; m_valid = 0; end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = 2;
            m_valid = 1;
            m_cnt   = $countones(m_cur);
            m_data  = recon(m_cnt);
          end
        end
        default: if (popped) begin m_cur = head; m_phase = 1; m_rem = T; end
      endcase
      if (spike_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(int'(spike_in));
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle compare plus a log of each presented result (rising valid).
  bit started = 0;
  bit prev_valid = 0;
  bit prev_sat = 0;
  int lg_data[$];
  int lg_cnt[$];
  int lg_cyc[$];
  int lg_sat[$];
  int valid_hi = 0;

  always @(negedge clk) begin
    if (started) begin
      check("valid", data_valid_out, m_valid);
      check("data_out", data_out, m_data);
      check("spike_count", spike_count, m_cnt);
      check("overflow", overflow, m_ovf);
      check("busy", busy, (m_q.size() > 0 || m_phase != 0) ? 1 : 0);
      if (data_valid_out) valid_hi++;
      if (data_valid_out && !prev_valid) begin
        lg_data.push_back(int'(data_out));
        lg_cnt.push_back(int'(spike_count));
        lg_cyc.push_back(cyc);
      end
      if (sat_valid && !prev_sat) lg_sat.push_back(int'(sat_data_out));
      prev_valid = data_valid_out;
      prev_sat   = sat_valid;
    end
  end

  int send_cyc;

  task automatic clear_logs();
    lg_data.delete(); lg_cnt.delete(); lg_cyc.delete(); lg_sat.delete();
    valid_hi = 0;
  endtask

  // Inputs change at negedge; the next posedge (cycle send_cyc) samples them.
  task automatic send(input logic [3:0] p);
    spike_valid = 1'b1;
    spike_in    = p;
    send_cyc    = cyc + 1;
    @(negedge clk);
    spike_valid = 1'b0;
    spike_in    = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || data_valid_out) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < budget) ? 1 : 0, 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!data_valid_out && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, data_valid_out, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; spike_valid = 1'b0; spike_in = 4'b0000; data_ready = 1'b1;
    @(negedge clk);
    started = 1;
    @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid_out, 0);
    check("rst_count", spike_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    idle(2);

    // Single train: 3 spikes -> 3*8/4 = 6. Valid is visible after the
    // (send+5)th edge, so the first edge to sample it high is send+6 = T+2.
    clear_logs();
    send(4'b1011);
    drain("single_drain", 40);
    check("single_n", lg_data.size(), 1);
    if (lg_data.size() == 1) begin
      check("single_data", lg_data[0], 6);
      check("single_cnt", lg_cnt[0], 3);
      check("single_latency", lg_cyc[0] - send_cyc, 5);
    end
    check("single_hold", valid_hi, 1);

    // Boundary counts; the THRESHOLD=255 copy gives 4*255/4 = 255.
    clear_logs();
    send(4'b0000);
    drain("zero_drain", 40);
    send(4'b1111);
    drain("full_drain", 40);
    check("bound_n", lg_data.size(), 2);
    if (lg_data.size() == 2) begin
      check("zero_data", lg_data[0], 0);
      check("full_data", lg_data[1], 8);
      check("full_cnt", lg_cnt[1], 4);
    end
    check("sat_n", lg_sat.size(), 2);
    if (lg_sat.size() == 2) check("sat_data", lg_sat[1], 255);

    // Backpressure: first result held for 10 cycles, then the buffered one.
    clear_logs();
    data_ready = 1'b0;
    send(4'b0111);
    idle(1);
    send(4'b0001);
    wait_valid("bp_wait", 20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", data_valid_out, 1);
      check("bp_hold_data", data_out, 6);
      check("bp_hold_cnt", spike_count, 3);
    end
    data_ready = 1'b1;
    drain("bp_drain", 40);
    check("bp_n", lg_data.size(), 2);
    if (lg_data.size() == 2) begin
      check("bp_first", lg_data[0], 6);
      check("bp_second", lg_data[1], 2);
    end

    // Push on a full FIFO in the cycle IDLE pops (edge 7 after A's push).
    clear_logs();
    send(4'b0001);
    idle(1);
    send(4'b0011);
    send(4'b0111);
    idle(3);
    send(4'b1111);
    drain("simul_drain", 80);
    check("simul_overflow", overflow, 0);
    check("simul_n", lg_data.size(), 4);
    if (lg_data.size() == 4) begin
      check("simul_0", lg_data[0], 2);
      check("simul_1", lg_data[1], 4);
      check("simul_2", lg_data[2], 6);
      check("simul_3", lg_data[3], 8);
    end

    // Overflow: four back-to-back trains, the fourth is dropped.
    clear_logs();
    send(4'b0001);
    send(4'b0011);
    send(4'b0111);
    send(4'b1111);
    check("ovf_set", overflow, 1);
    drain("ovf_drain", 80);
    check("ovf_sticky", overflow, 1);
    check("ovf_n", lg_data.size(), 3);
    if (lg_data.size() == 3) begin
      check("ovf_0", lg_data[0], 2);
      check("ovf_1", lg_data[1], 4);
      check("ovf_2", lg_data[2], 6);
    end

    // Reset in the middle of a decode discards everything.
    clear_logs();
    send(4'b1111);
    idle(2);
    check("mid_busy_pre", busy, 1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("mid_overflow", overflow, 0);
    check("mid_busy", busy, 0);
    check("mid_valid", data_valid_out, 0);
    check("mid_data", data_out, 0);
    idle(12);
    check("mid_no_output", lg_data.size(), 0);
    check("mid_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
